// File: rtl/invaders_wave_ctrl_if.sv
// Signal bundle between the game sequencer and its environment (game FSM and invaders block).
// The master side drives the start/hit/formation inputs; the slave is the sequencer itself.
interface invaders_wave_ctrl_if;
  logic        i_start;
  logic        i_hit;
  logic [19:0] i_invaders_array;
  logic [3:0]  i_invaders_row;
  logic        o_invaders_reset;
  logic        o_step;
  logic [4:0]  o_alive;
  logic [3:0]  o_wave;
  logic [11:0] o_score;
  logic [2:0]  o_state;
  logic        o_game_over;

  modport master (
    output i_start, i_hit, i_invaders_array, i_invaders_row,
    input  o_invaders_reset, o_step, o_alive, o_wave, o_score, o_state, o_game_over
  );

  modport slave (
    input  i_start, i_hit, i_invaders_array, i_invaders_row,
    output o_invaders_reset, o_step, o_alive, o_wave, o_score, o_state, o_game_over
  );
endinterface

// File: rtl/invaders_wave_ctrl.sv
// Wave sequencer for the invaders formation: holds it in reset between waves, paces it with a
// step strobe that speeds up each wave, and tracks wave number and score.
module invaders_wave_ctrl #(
  parameter int unsigned BASE_PERIOD  = 3600000,
  parameter int unsigned LOAD_CYCLES  = 36,
  parameter int unsigned PAUSE_CYCLES = 36000000,
  parameter int unsigned BOTTOM_ROW   = 14
) (
  input  logic                       i_clk_36MHz,
  input  logic                       i_reset,
  invaders_wave_ctrl_if.slave        bus_io
);

  localparam int unsigned CntMax = (LOAD_CYCLES > PAUSE_CYCLES) ? LOAD_CYCLES : PAUSE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned StepW  = $clog2(BASE_PERIOD + 1);

  localparam logic [CntW-1:0] LoadLast  = CntW'(LOAD_CYCLES - 1);
  localparam logic [CntW-1:0] PauseLast = CntW'(PAUSE_CYCLES - 1);
  localparam logic [3:0]      BottomRow = 4'(BOTTOM_ROW);
  localparam logic [11:0]     ScoreMax  = 12'hFFF;
  localparam logic [3:0]      WaveMax   = 4'hF;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StPlay  = 3'd2,
    StClear = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [StepW-1:0] step_cnt_q, step_cnt_d;
  logic             step_q, step_d;
  logic             inv_rst_q, inv_rst_d;
  logic             over_q, over_d;
  logic             hit_q;
  logic [3:0]       wave_q, wave_d;
  logic [11:0]      score_q, score_d;

  logic [1:0]       shift;
  logic [StepW-1:0] period_m1;
  logic             hit_rise;
  logic [4:0]       alive;

  // Step period halves each wave until the shift saturates at 3.
  always_comb begin
    shift     = (wave_q >= 4'd3) ? 2'd3 : wave_q[1:0];
    period_m1 = StepW'(BASE_PERIOD >> shift) - StepW'(1);
  end

  assign hit_rise = bus_io.i_hit & ~hit_q;

  always_comb begin
    alive = '0;
    for (int i = 0; i < 20; i++) begin
      alive = alive + 5'(bus_io.i_invaders_array[i]);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    step_cnt_d = step_cnt_q;
    wave_d     = wave_q;
    score_d    = score_q;

    unique case (state_q)
      StIdle, StOver: begin
        if (bus_io.i_start) begin
          state_d = StLoad;
          wave_d  = '0;
          score_d = '0;
        end
      end
      StLoad: begin
        if (cnt_q == LoadLast) begin
          state_d    = StPlay;
          step_cnt_d = period_m1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPlay: begin
        step_cnt_d = (step_cnt_q == '0) ? period_m1 : step_cnt_q - StepW'(1);
        // A hit on the exit cycle still scores.
        if (hit_rise && (score_q != ScoreMax)) begin
          score_d = score_q + 12'd1;
        end
        if (bus_io.i_invaders_array == '0) begin
          state_d = StClear;
        end else if (bus_io.i_invaders_row >= BottomRow) begin
          state_d = StOver;
        end
      end
      StClear: begin
        if (cnt_q == PauseLast) begin
          state_d = StLoad;
          if (wave_q != WaveMax) begin
            wave_d = wave_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // No strobe on the cycle that leaves PLAY.
    step_d    = (state_q == StPlay) && (state_d == StPlay) && (step_cnt_q == '0);
    inv_rst_d = (state_d != StPlay);
    over_d    = (state_d == StOver);
  end

  always_ff @(posedge i_clk_36MHz) begin
    if (i_reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      step_cnt_q <= '0;
      step_q     <= 1'b0;
      inv_rst_q  <= 1'b1;
      over_q     <= 1'b0;
      hit_q      <= 1'b0;
      wave_q     <= '0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_cnt_q <= step_cnt_d;
      step_q     <= step_d;
      inv_rst_q  <= inv_rst_d;
      over_q     <= over_d;
      hit_q      <= bus_io.i_hit;
      wave_q     <= wave_d;
      score_q    <= score_d;
    end
  end

  assign bus_io.o_invaders_reset = inv_rst_q;
  assign bus_io.o_step           = step_q;
  assign bus_io.o_alive          = alive;
  assign bus_io.o_wave           = wave_q;
  assign bus_io.o_score          = score_q;
  assign bus_io.o_state          = state_q;
  assign bus_io.o_game_over      = over_q;

endmodule

// File: tb/tb_invaders_wave_ctrl.sv
// Scoreboard bench for invaders_wave_ctrl: rounds are planned as edge timestamps, expected
// output events are queued, and a negedge monitor pops and compares each DUT output event.
module tb_invaders_wave_ctrl;
  localparam int unsigned BASE   = 16;
  localparam int unsigned LOADC  = 4;
  localparam int unsigned PAUSE  = 8;
  localparam int unsigned BOTTOM = 14;

  localparam logic [2:0] SIdle = 3'd0, SLoad = 3'd1, SPlay = 3'd2, SClear = 3'd3, SOver = 3'd4;
  localparam int ExClear = 0, ExOver = 1, ExBoth = 2, ExReset = 3;

  typedef struct packed {
    logic [2:0]  state;
    logic [3:0]  wave;
    logic [11:0] score;
    logic        step;
    logic        inv;
    logic        go;
  } snap_t;

  typedef struct {
    int    edge_n;
    snap_t s;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  invaders_wave_ctrl_if bus ();

  invaders_wave_ctrl #(
    .BASE_PERIOD (BASE),
    .LOAD_CYCLES (LOADC),
    .PAUSE_CYCLES(PAUSE),
    .BOTTOM_ROW  (BOTTOM)
  ) dut (
    .i_clk_36MHz(clk),
    .i_reset    (rst),
    .bus_io     (bus)
  );

  always #5 clk = ~clk;

  ev_t   exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    now = 0;
  bit    mon_on = 1'b0;
  bit    last_hit = 1'b0;
  int    m_wave = 0;
  int    m_score = 0;
  int    clear_edge = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    now++;
  endtask

  function automatic snap_t mk(input logic [2:0] st, input int w, input int s, input bit stp);
    snap_t r;
    r.state = st;
    r.wave  = 4'(w);
    r.score = 12'(s);
    r.step  = stp;
    r.inv   = (st != SPlay);
    r.go    = (st == SOver);
    return r;
  endfunction

  task automatic push(input int e, input snap_t s);
    ev_t ev;
    ev.edge_n = e;
    ev.s      = s;
    exp_q.push_back(ev);
  endtask

  // Monitor: an output event is any change of the registered outputs or a step pulse.
  snap_t prev;
  bit    first = 1'b1;
  always @(negedge clk) begin : mon
    snap_t cur;
    ev_t   ev;
    if (mon_on) begin
      total++;
      if (bus.o_alive != 5'($countones(bus.i_invaders_array))) begin
        bad++;
        $display("FAIL alive edge=%0d got=%0d want=%0d", now, bus.o_alive,
                 $countones(bus.i_invaders_array));
      end
      cur.state = bus.o_state;
      cur.wave  = bus.o_wave;
      cur.score = bus.o_score;
      cur.step  = bus.o_step;
      cur.inv   = bus.o_invaders_reset;
      cur.go    = bus.o_game_over;
      if (first || cur.step ||
          ({cur.state, cur.wave, cur.score, cur.inv, cur.go} !=
           {prev.state, prev.wave, prev.score, prev.inv, prev.go})) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event edge=%0d st=%0d wave=%0d score=%0d step=%0b", now,
                   cur.state, cur.wave, cur.score, cur.step);
        end else begin
          ev = exp_q.pop_front();
          if (ev.edge_n != now || ev.s != cur) begin
            bad++;
            $display("FAIL event got edge=%0d st=%0d wave=%0d score=%0d step=%0b inv=%0b go=%0b want edge=%0d st=%0d wave=%0d score=%0d step=%0b inv=%0b go=%0b",
                     now, cur.state, cur.wave, cur.score, cur.step, cur.inv, cur.go,
                     ev.edge_n, ev.s.state, ev.s.wave, ev.s.score, ev.s.step, ev.s.inv,
                     ev.s.go);
          end
        end
      end
      prev  = cur;
      first = 1'b0;
    end
  end

  // Cycles spent in IDLE or OVER with random inputs; nothing is expected to change.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_start          = 1'b0;
      bus.i_hit            = ($urandom_range(0, 1) == 1);
      bus.i_invaders_array = 20'($urandom);
      bus.i_invaders_row   = 4'($urandom_range(0, 15));
      last_hit             = bus.i_hit;
      tick();
    end
  endtask

  // One round: (start or pause) -> LOAD -> PLAY for plen cycles -> exit of kind exk.
  task automatic round(input bit do_start, input int exk, input int plen, input int hmode);
    int    l_e, pe, x_e, per, w, s, hold, n, base, e, d;
    bit    hv[];
    bit    scored, changed, stp;
    logic [2:0] st;
    l_e  = do_start ? now + 1 : clear_edge + int'(PAUSE);
    pe   = l_e + int'(LOADC);
    x_e  = pe + plen;
    w    = do_start ? 0 : ((m_wave < 15) ? m_wave + 1 : 15);
    s    = do_start ? 0 : m_score;
    per  = int'(BASE) / (1 << ((w < 3) ? w : 3));
    hold = $urandom_range(1, LOADC + 3);
    if (hold > x_e - l_e) hold = x_e - l_e;
    base = now;
    n    = x_e - base;
    hv   = new[n + 1];
    hv[0] = last_hit;
    for (int i = 1; i <= n; i++) begin
      e = base + i;
      d = e - pe;
      case (hmode)
        1, 3:    hv[i] = ($urandom_range(0, 2) == 0);
        2:       hv[i] = (d > 0) && (d % 2 == 1);
        4:       hv[i] = (d >= 2) && (d <= 10) && (d % 2 == 0);
        5:       hv[i] = (d == 3) || (d == 4) || (d == 5) || (d == 7);
        default: hv[i] = 1'b0;
      endcase
    end
    if (hmode == 3) begin
      hv[n]     = 1'b1;
      hv[n - 1] = 1'b0;
    end
    for (int i = 1; i <= n; i++) begin
      e = base + i;
      bus.i_start = do_start && (e >= l_e) && (e < l_e + hold);
      bus.i_hit   = hv[i];
      rst         = (exk == ExReset) && (e == x_e);
      if (e == x_e && (exk == ExClear || exk == ExBoth)) begin
        bus.i_invaders_array = '0;
        bus.i_invaders_row   = (exk == ExBoth) ? 4'($urandom_range(BOTTOM, 15))
                                               : 4'($urandom_range(0, 15));
      end else begin
        bus.i_invaders_array = 20'($urandom_range(1, 20'hFFFFF));
        bus.i_invaders_row   = (e == x_e && exk == ExOver) ? 4'($urandom_range(BOTTOM, 15))
                                                           : 4'($urandom_range(0, BOTTOM - 1));
      end
      scored  = hv[i] && !hv[i - 1] && (e > pe) && !(exk == ExReset && e == x_e);
      changed = 1'b0;
      if (scored && s < 4095) begin
        s++;
        changed = 1'b1;
      end
      stp = (e > pe) && (e < x_e) && ((e - pe) % per == 0);
      if (e < pe) st = SLoad;
      else if (e < x_e) st = SPlay;
      else if (exk == ExOver) st = SOver;
      else if (exk == ExReset) st = SIdle;
      else st = SClear;
      if (e == l_e || e == pe || e == x_e || stp || changed) begin
        if (exk == ExReset && e == x_e) push(e, mk(SIdle, 0, 0, 1'b0));
        else push(e, mk(st, w, s, stp));
      end
      tick();
    end
    rst                  = 1'b0;
    bus.i_start          = 1'b0;
    bus.i_invaders_array = 20'($urandom_range(1, 20'hFFFFF));
    bus.i_invaders_row   = 4'($urandom_range(0, BOTTOM - 1));
    last_hit             = hv[n];
    if (exk == ExReset) begin
      m_wave      = 0;
      m_score     = 0;
      bus.i_hit   = 1'b0;
      last_hit    = 1'b0;
    end else begin
      m_wave  = w;
      m_score = s;
    end
    if (exk == ExClear || exk == ExBoth) clear_edge = x_e;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog edge=%0d pending=%0d", now, exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin : driver
    bit in_clear;
    int exk;
    rst                  = 1'b1;
    bus.i_start          = 1'b0;
    bus.i_hit            = 1'b0;
    bus.i_invaders_array = 20'h00001;
    bus.i_invaders_row   = 4'd0;
    tick();
    tick();
    push(now, mk(SIdle, 0, 0, 1'b0));
    mon_on = 1'b1;
    rst    = 1'b0;
    idle(3);

    // Basic waves: periods 16 then 8, hit pattern 3-high/low/1-high, then a landing.
    round(1'b1, ExClear, 40, 1);
    round(1'b0, ExClear, 30, 5);
    round(1'b0, ExOver, 25, 1);
    idle(6);
    // Simultaneous clear and landing with a hit edge on the same cycle.
    round(1'b1, ExBoth, 20, 3);
    round(1'b0, ExOver, 15, 1);
    idle(4);
    // Reset mid-PLAY at wave 2 with score 5.
    round(1'b1, ExClear, 12, 0);
    round(1'b0, ExClear, 12, 0);
    round(1'b0, ExReset, 20, 4);
    idle(3);
    // Wave saturation and shortest period.
    round(1'b1, ExClear, $urandom_range(5, 30), 1);
    for (int k = 0; k < 16; k++) round(1'b0, ExClear, $urandom_range(5, 30), 1);
    // Score saturation, then frozen score in OVER.
    round(1'b0, ExOver, 8300, 2);
    idle(6);
    // Random rounds; always end in OVER so nothing is pending.
    in_clear = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exk = (k == 9) ? ExOver : int'($urandom_range(0, 3));
      round(!in_clear, exk, $urandom_range(1, 40), ($urandom_range(0, 1) == 1) ? 1 : 3);
      in_clear = (exk == ExClear || exk == ExBoth);
      if (!in_clear) idle($urandom_range(0, 5));
    end
    idle(5);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
